// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one external memory port between four
// requesters. Each transfer runs IDLE -> BUS -> DONE, with an ack timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [3:0]          we,
  input  logic [4*ADDR_W-1:0] addr,
  input  logic [4*DATA_W-1:0] wdata,
  output logic [3:0]          gnt,
  output logic [3:0]          done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_rd,
  output logic                mem_wr,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  // Last BUS cycle index before giving up on mem_ack.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          win_q, win_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [3:0]          done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;

  logic                found;
  logic [1:0]          pick;
  logic [1:0]          idx;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;

  // Round-robin search: first requester with req high starting at ptr.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Mux out the winner's address and write data.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (pick == 2'(i)) begin
        addr_sel  = addr[i*ADDR_W +: ADDR_W];
        wdata_sel = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = 4'b0001 << pick;
          win_d   = pick;
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
          rd_d    = ~we[pick];
          wr_d    = we[pick];
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + 8'd1;
        // Ack wins over the timeout when both land on the same cycle.
        if (mem_ack) begin
          if (rd_q) rdata_d = mem_rdata;
          err_d   = 1'b0;
          done_d  = gnt_q;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          done_d  = gnt_q;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = win_q + 2'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req, we;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [3:0]      gnt, done;
  logic            err;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd, mem_wr, mem_ack;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: one transaction record (who, direction, latched operands,
  // how many bus cycles have elapsed, whether it has finished).
  bit          m_act, m_fin, m_we, m_err;
  int          m_ptr, m_who, m_elapsed;
  logic [31:0] m_addr, m_wdata, m_rdata;

  initial begin
    m_act = 0; m_fin = 0; m_we = 0; m_err = 0;
    m_ptr = 0; m_who = 0; m_elapsed = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0;
    forever begin
      @(posedge clk);
      cyc_cnt++;
      if (rst) begin
        m_act = 0; m_fin = 0; m_ptr = 0; m_rdata = 0; m_err = 0;
        chk_en = 1'b1;
      end else if (!m_act) begin
        if (req != 4'b0) begin
          for (int k = 3; k >= 0; k--)
            if (req[(m_ptr + k) % 4]) m_who = (m_ptr + k) % 4;
          m_act = 1; m_fin = 0; m_elapsed = 0;
          m_we = we[m_who];
          m_addr = addr[m_who*AW +: AW];
          m_wdata = wdata[m_who*DW +: DW];
        end
      end else if (m_fin) begin
        m_act = 0; m_fin = 0;
        m_ptr = (m_who + 1) % 4;
      end else begin
        m_elapsed++;
        if (mem_ack) begin
          if (!m_we) m_rdata = mem_rdata;
          m_err = 0; m_fin = 1;
        end else if (m_elapsed == TO) begin
          m_err = 1; m_fin = 1;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  logic [3:0] e_gnt, e_done;
  logic       e_rd, e_wr;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_gnt  = m_act ? 4'(1 << m_who) : 4'b0;
        e_done = (m_act && m_fin) ? 4'(1 << m_who) : 4'b0;
        e_rd   = m_act && !m_fin && !m_we;
        e_wr   = m_act && !m_fin && m_we;
        chk("cyc_gnt", gnt, e_gnt);
        chk("cyc_done", done, e_done);
        chk("cyc_mem_rd", mem_rd, e_rd);
        chk("cyc_mem_wr", mem_wr, e_wr);
        chk("cyc_rdata", rdata, m_rdata);
        if (e_done != 4'b0) chk("cyc_err", err, m_err);
        if (e_rd || e_wr) begin
          chk("cyc_mem_addr", mem_addr, m_addr);
          chk("cyc_mem_wdata", mem_wdata, m_wdata);
        end
      end
    end
  end

  task automatic wait_gnt(input int budget, output int who);
    who = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt != 4'b0) begin
        for (int k = 0; k < 4; k++) if (gnt[k]) who = k;
        return;
      end
    end
    chk("wait_gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done != 4'b0) begin
        at = cyc_cnt;
        return;
      end
    end
    chk("wait_done_timeout", 64'd0, 64'd1);
  endtask

  int who, at, last_at, wr_cycles;
  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1; req = 0; we = 0; addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 0;

    // Single read with immediate ack.
    req = 4'b0001; we = 4'b0000; addr[31:0] = 32'h100;
    @(negedge clk);
    chk("rd_gnt", gnt, 4'b0001);
    chk("rd_strobe", mem_rd, 1);
    chk("rd_addr", mem_addr, 32'h100);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_done", done, 4'b0001);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_err", err, 0);
    chk("rd_strobe_low", mem_rd, 0);
    chk("model_rdata", m_rdata, 32'hDEADBEEF);
    mem_ack = 0; req = 0;
    @(negedge clk);
    chk("rd_idle_gnt", gnt, 0);
    chk("rd_idle_done", done, 0);

    // Round robin with all four requesting and immediate ack.
    rst = 1; @(negedge clk); rst = 0;
    req = 4'hF; we = 4'b1010; mem_ack = 1; mem_rdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      addr[i*AW +: AW]  = 32'h1000 + 32'(i) * 32'h10;
      wdata[i*DW +: DW] = 32'(i) * 32'h11;
    end
    last_at = 0;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(10, who);
      chk("rr_order", 64'(who), 64'(rr_exp[n]));
      wait_done(10, at);
      if (n > 0) chk("rr_spacing", 64'(at - last_at), 64'd3);
      last_at = at;
    end
    req = 0; mem_ack = 0;

    // Fairness: requester 1 finishes, requester 0 must win next.
    rst = 1; @(negedge clk); rst = 0;
    req = 4'b0010; we = 4'b0000;
    wait_gnt(10, who);
    chk("fair_first", 64'(who), 64'd1);
    req = 4'b0011; mem_ack = 1; mem_rdata = 32'hA5A50001;
    wait_done(10, at);
    chk("fair_done1", done, 4'b0010);
    wait_gnt(10, who);
    chk("fair_next", 64'(who), 64'd0);
    wait_done(10, at);
    req = 0; mem_ack = 0;
    @(negedge clk);

    // Timeout: requester 2 write, never acked; operands change mid-bus.
    req = 4'b0100; we = 4'b0100; addr[2*AW +: AW] = 32'h20; wdata[2*DW +: DW] = 32'h55;
    wait_gnt(10, who);
    chk("to_who", 64'(who), 64'd2);
    chk("to_addr", mem_addr, 32'h20);
    chk("to_wdata", mem_wdata, 32'h55);
    addr[2*AW +: AW] = 32'hFFFF; wdata[2*DW +: DW] = 32'hAA; req = 0;
    wr_cycles = mem_wr ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_wr) break;
      wr_cycles++;
    end
    chk("to_wr_cycles", 64'(wr_cycles), 64'd4);
    chk("to_done", done, 4'b0100);
    chk("to_err", err, 1);
    chk("model_err_to", 64'(m_err), 64'd1);
    @(negedge clk);

    // Reset in the middle of a read.
    req = 4'b0001; we = 4'b0000;
    wait_gnt(10, who);
    chk("rmt_rd_before", mem_rd, 1);
    rst = 1;
    @(negedge clk);
    chk("rmt_rd", mem_rd, 0);
    chk("rmt_wr", mem_wr, 0);
    chk("rmt_gnt", gnt, 0);
    chk("rmt_done", done, 0);
    rst = 0; req = 4'b1000; we = 4'b0000;
    wait_gnt(10, who);
    chk("rmt_who", 64'(who), 64'd3);
    mem_ack = 1; mem_rdata = 32'h33333333;
    wait_done(10, at);
    chk("rmt_done3", done, 4'b1000);
    mem_ack = 0; req = 0;
    @(negedge clk);

    // Ack on the last allowed bus cycle counts as success.
    req = 4'b0010; we = 4'b0000; addr[1*AW +: AW] = 32'h44; mem_rdata = 32'hCAFEF00D;
    wait_gnt(10, who);
    repeat (3) @(negedge clk);
    chk("co_rd_still", mem_rd, 1);
    mem_ack = 1;
    @(negedge clk);
    chk("co_done", done, 4'b0010);
    chk("co_err", err, 0);
    chk("co_rdata", rdata, 32'hCAFEF00D);
    chk("model_err_co", 64'(m_err), 64'd0);
    mem_ack = 0; req = 0;
    @(negedge clk);

    // Stray ack while idle.
    mem_ack = 1; mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    mem_ack = 0;
    chk("stray_done", done, 0);
    chk("stray_gnt", gnt, 0);
    chk("stray_rdata", rdata, 32'hCAFEF00D);
    @(negedge clk);
    chk("stray_done2", done, 0);
    chk("stray_rd", mem_rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single external memory port between four requesters. Index 0 is command fetch, 1 is the operand read phases (COND/SRC1/SRC0/DST pointer reads), 2 is the result write phases (WRITE_DST/COND/SRC), and 3 is the debug/loader port. Each transfer uses a req/gnt/done handshake with round-robin fairness and an ack timeout. The block sits between the state-sequencing logic and the memory bus.

## Interface
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width.
- TIMEOUT, default 16: maximum BUS-state cycles to wait for mem_ack. Legal range 2..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  4  per-requester transfer request. Level signal, held until the matching done.
- we  in  4  per-requester direction: 1 = write, 0 = read. Sampled with the request.
- addr  in  4*ADDR_W  packed per-requester address; requester i occupies [i*ADDR_W +: ADDR_W].
- wdata  in  4*DATA_W  packed per-requester write data.
- gnt  out  4  one-hot grant; all zeros when idle.
- done  out  4  one-cycle completion pulse to the granted requester.
- err  out  1  valid with done; 1 = transfer timed out.
- rdata  out  DATA_W  read data, valid while done is high and held until the next read completes.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion.

## Operation
- States are IDLE, BUS and DONE, with a 2-bit round-robin pointer `ptr`.
- IDLE:
  - If req is nonzero, the winner is the first requester with req high, searching ptr, ptr+1, … modulo 4.
  - On the same edge, register gnt = one-hot(winner), latch we/addr/wdata of the winner, clear the timeout counter, and go to BUS.
  - If req is zero, stay in IDLE.
- BUS:
  - mem_rd = ~we_latched and mem_wr = we_latched. mem_addr and mem_wdata are driven from the latched values. Strobes are held constant.
  - The counter increments every BUS cycle.
  - If mem_ack is sampled high: for a read, latch rdata from mem_rdata; set err_next = 0; go to DONE.
  - Else, if the counter equals TIMEOUT-1: set err_next = 1, leave rdata unchanged, and go to DONE.
- DONE:
  - Strobes are low, done[winner] = 1, err is valid, and gnt stays asserted.
  - Next edge: gnt becomes 0, ptr becomes winner+1 (mod 4), and the FSM returns to IDLE.
- Dropping req during BUS does not abort the transfer; it completes and done still pulses.
- A requester that keeps req high after done is treated as a new request and competes under round-robin.
- Requests are not queued; req is a level signal only.
- mem_ack while not in BUS is ignored.
- Address and data are latched once, in the IDLE→BUS edge; later changes on addr/wdata have no effect.
- Width rules: all ports are fixed-width and nothing is truncated. The counter is 8 bits.

## Timing
- Reset values: gnt = 0, done = 0, err = 0, rdata = 0, mem_rd = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0, ptr = 0, state = IDLE.
- Reset mid-transfer: the strobes drop on the first rst edge, the transfer is lost, and no done is issued.
- All outputs are registered.
- Latency for req first high at edge E0, with mem_ack in the first BUS cycle:
  - gnt and strobe are high after E0.
  - mem_ack is sampled at E1, so done is high after E1.
  - The FSM is in IDLE after E2.
  - Minimum 3 cycles per transfer; no back-to-back overlap.
- Each extra wait cycle without mem_ack adds one cycle.
- Timeout: with no ack, the strobes stay high for exactly TIMEOUT cycles, then there is one DONE cycle with err = 1.
- A simultaneous ack and timeout-limit in the same cycle counts as ack, so err = 0.
- gnt is always one-hot or zero, and never changes while in BUS.

## Test plan
- **Single read:** req = 0001, we = 0, addr0 = 0x100; mem_ack on the first BUS cycle with mem_rdata = 0xDEADBEEF. Required: mem_rd for 1 cycle, mem_addr = 0x100, done = 0001 on the next cycle with rdata = 0xDEADBEEF and err = 0.
- **Round-robin order:** req = 1111 held continuously, ack immediate. Required: grant order 0, 1, 2, 3, 0, with a done every 3 cycles.
- **Timeout:** TIMEOUT = 4, requester 2 writes wdata = 0x55 to 0x20, mem_ack never asserted. Required: mem_wr high for exactly 4 cycles, then done = 0100 with err = 1.
- **Fairness after release:** ptr = 0, requester 1 granted and completes, req = 0011 still held. Required: next grant is requester 0, not requester 1.
- **Reset mid-transfer:** rst asserted for one edge while in BUS. Required: next cycle mem_rd = mem_wr = gnt = done = 0, state IDLE, ptr = 0, and a subsequent req = 1000 is granted normally.
- **Ack/timeout coincidence and stray ack:** mem_ack arrives on the last allowed BUS cycle. Required: err = 0 with rdata updated. Also, mem_ack pulsed in IDLE causes no done and no state change.
